// File: rtl/count_cmp_pkg.sv
// Shared definitions for the count compare/capture block: register word
// indices, CTRL/STATUS bit positions and small helpers.
package count_cmp_pkg;

  typedef enum logic [2:0] {
    ADDR_CTRL      = 3'd0,
    ADDR_CMP0      = 3'd1,
    ADDR_CMP1      = 3'd2,
    ADDR_STATUS    = 3'd3,
    ADDR_FIFO_DATA = 3'd4,
    ADDR_LEVEL     = 3'd5
  } reg_addr_e;

  localparam int CTRL_CMP0_EN    = 0;
  localparam int CTRL_CMP1_EN    = 1;
  localparam int CTRL_CAP_EN     = 2;
  localparam int CTRL_IRQ_EN_LSB = 4;

  localparam int STATUS_M0  = 0;
  localparam int STATUS_M1  = 1;
  localparam int STATUS_OVF = 2;

  // A FIFO entry carries the {m1,m0} tag above the captured count.
  function automatic int entry_width(input int bits);
    return bits + 2;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/count_cmp_capture_fifo.sv
// First-word fall-through capture FIFO; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module capture_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    occupancy;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occupancy == '0);
  assign full    = (occupancy == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = occupancy;
  // Reading an empty FIFO returns zero rather than stale storage.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + LW'(1);
        2'b01:   occupancy <= occupancy - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/count_cmp_capture.sv
// Compares the live counter against two programmable values, timestamps
// match events into a capture FIFO and raises level interrupts.
module count_cmp_capture
  import count_cmp_pkg::*;
#(
  parameter int BITS       = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count,
  output logic [2:0]      user_irq
);

  localparam int EW = entry_width(BITS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]      en;
  logic [2:0]      irq_en;
  logic [BITS-1:0] cmp0;
  logic [BITS-1:0] cmp1;
  logic            m0, m1, ovf;
  logic            prev_hit0, prev_hit1;

  logic            valid, access, wr, rd;
  logic [2:0]      addr;
  logic            hit0, hit1, ev0, ev1;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_set;
  logic [LW-1:0]   fifo_level;
  logic [EW-1:0]   fifo_rdata;
  logic [2:0]      status_clr;
  logic [31:0]     rd_word, cmp0_word, cmp1_word;
  logic            unused_ok;

  assign valid  = wbs_cyc_i & wbs_stb_i;
  assign access = valid & ~wbs_ack_o;
  assign wr     = access & wbs_we_i;
  assign rd     = access & ~wbs_we_i;
  assign addr   = wbs_adr_i[4:2];

  // Events are rising edges of the hit condition, so a stalled count fires once.
  assign hit0 = en[CTRL_CMP0_EN] & (count == cmp0);
  assign hit1 = en[CTRL_CMP1_EN] & (count == cmp1);
  assign ev0  = hit0 & ~prev_hit0;
  assign ev1  = hit1 & ~prev_hit1;

  assign fifo_push = en[CTRL_CAP_EN] & (ev0 | ev1);
  assign fifo_pop  = rd & (addr == ADDR_FIFO_DATA);
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;

  assign status_clr = (wr && addr == ADDR_STATUS && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;
  assign cmp0_word  = byte_merge(32'(cmp0), wbs_dat_i, wbs_sel_i);
  assign cmp1_word  = byte_merge(32'(cmp1), wbs_dat_i, wbs_sel_i);

  assign user_irq = {(~fifo_empty | ovf) & irq_en[2], m1 & irq_en[1], m0 & irq_en[0]};

  assign unused_ok = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0],
                       cmp0_word[31:BITS], cmp1_word[31:BITS]};

  capture_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({ev1, ev0, count}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .rdata (fifo_rdata)
  );

  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_word[CTRL_CAP_EN:CTRL_CMP0_EN] = en;
        rd_word[CTRL_IRQ_EN_LSB +: 3]     = irq_en;
      end
      ADDR_CMP0:   rd_word = 32'(cmp0);
      ADDR_CMP1:   rd_word = 32'(cmp1);
      ADDR_STATUS: begin
        rd_word[STATUS_M0]  = m0;
        rd_word[STATUS_M1]  = m1;
        rd_word[STATUS_OVF] = ovf;
      end
      ADDR_FIFO_DATA: begin
        rd_word[31:30]     = fifo_rdata[EW-1 -: 2];
        rd_word[BITS-1:0]  = fifo_rdata[BITS-1:0];
      end
      ADDR_LEVEL:  rd_word[LW-1:0] = fifo_level;
      default:     ;
    endcase
  end

  // Sticky status: a hardware set in the same cycle as a W1C keeps the bit.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en        <= '0;
      irq_en    <= '0;
      cmp0      <= '0;
      cmp1      <= '0;
      m0        <= 1'b0;
      m1        <= 1'b0;
      ovf       <= 1'b0;
      prev_hit0 <= 1'b0;
      prev_hit1 <= 1'b0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= rd ? rd_word : '0;
      prev_hit0 <= hit0;
      prev_hit1 <= hit1;
      if (wr) begin
        case (addr)
          ADDR_CTRL: begin
            if (wbs_sel_i[0]) begin
              en     <= wbs_dat_i[CTRL_CAP_EN:CTRL_CMP0_EN];
              irq_en <= wbs_dat_i[CTRL_IRQ_EN_LSB +: 3];
            end
          end
          ADDR_CMP0: cmp0 <= cmp0_word[BITS-1:0];
          ADDR_CMP1: cmp1 <= cmp1_word[BITS-1:0];
          default:   ;
        endcase
      end
      m0  <= ev0 | (m0 & ~status_clr[STATUS_M0]);
      m1  <= ev1 | (m1 & ~status_clr[STATUS_M1]);
      ovf <= ovf_set | (ovf & ~status_clr[STATUS_OVF]);
    end
  end

endmodule

// File: tb/tb_count_cmp_capture.sv
// Bench for count_cmp_capture: directed scenarios with literal expectations
// plus randomized bus/count traffic checked every cycle against a queue model.
module tb_count_cmp_capture;

  localparam int BITS  = 30;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     dat_i, adr;
  logic            ack;
  logic [31:0]     dat_o;
  logic [BITS-1:0] count;
  logic [2:0]      irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_cmp_capture #(.BITS(BITS), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .count     (count),
    .user_irq  (irq)
  );

  // Reference model: register contents as plain variables, FIFO as a queue.
  logic [2:0]      m_en = '0, m_irq_en = '0;
  logic [BITS-1:0] m_cmp0 = '0, m_cmp1 = '0;
  logic            m_m0 = 0, m_m1 = 0, m_ovf = 0, m_prev0 = 0, m_prev1 = 0;
  logic [31:0]     m_q[$];
  logic            m_ack = 0;
  logic [31:0]     m_dat = '0;

  always @(posedge clk or negedge rst_n) begin : model
    logic        fire, h0, h1, e0, e1, pop, push, was_full;
    logic [2:0]  a;
    logic [31:0] rdv, merged;
    if (!rst_n) begin
      m_en = '0; m_irq_en = '0; m_cmp0 = '0; m_cmp1 = '0;
      m_m0 = 0; m_m1 = 0; m_ovf = 0; m_prev0 = 0; m_prev1 = 0;
      m_q.delete();
      m_ack = 0; m_dat = '0;
    end else begin
      a    = adr[4:2];
      fire = cyc && stb && !m_ack;
      h0   = m_en[0] && (count == m_cmp0);
      h1   = m_en[1] && (count == m_cmp1);
      e0   = h0 && !m_prev0;
      e1   = h1 && !m_prev1;
      rdv  = '0;
      if (fire && !we) begin
        case (a)
          3'd0: rdv = {25'd0, m_irq_en, 1'b0, m_en};
          3'd1: rdv = 32'(m_cmp0);
          3'd2: rdv = 32'(m_cmp1);
          3'd3: rdv = {29'd0, m_ovf, m_m1, m_m0};
          3'd4: rdv = (m_q.size() > 0) ? m_q[0] : 32'd0;
          3'd5: rdv = 32'(m_q.size());
          default: rdv = '0;
        endcase
      end
      if (fire && we && a == 3'd3 && sel[0]) begin
        if (dat_i[0]) m_m0 = 0;
        if (dat_i[1]) m_m1 = 0;
        if (dat_i[2]) m_ovf = 0;
      end
      pop      = fire && !we && a == 3'd4 && m_q.size() > 0;
      push     = m_en[2] && (e0 || e1);
      was_full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!was_full || pop) m_q.push_back({e1, e0, count});
        else m_ovf = 1;
      end
      if (e0) m_m0 = 1;
      if (e1) m_m1 = 1;
      if (fire && we) begin
        case (a)
          3'd0: if (sel[0]) begin m_en = dat_i[2:0]; m_irq_en = dat_i[6:4]; end
          3'd1, 3'd2: begin
            merged = (a == 3'd1) ? 32'(m_cmp0) : 32'(m_cmp1);
            for (int b = 0; b < 4; b++) if (sel[b]) merged[b*8 +: 8] = dat_i[b*8 +: 8];
            if (a == 3'd1) m_cmp0 = merged[BITS-1:0];
            else m_cmp1 = merged[BITS-1:0];
          end
          default: ;
        endcase
      end
      m_prev0 = h0;
      m_prev1 = h1;
      m_ack   = fire;
      m_dat   = rdv;
    end
  end

  function automatic logic [2:0] model_irq();
    return {(m_q.size() > 0 || m_ovf) && m_irq_en[2], m_m1 && m_irq_en[1], m_m0 && m_irq_en[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cyc_ack", 32'(ack), 32'(m_ack));
    checkOutput("cyc_rdata", dat_o, m_dat);
    checkOutput("cyc_irq", 32'(irq), 32'(model_irq()));
  end

  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic [3:0] s, input logic set_cnt,
                               input logic [BITS-1:0] cnt, output logic [31:0] r);
    bit got;
    got = 0;
    r   = '0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    if (set_cnt) count = cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin got = 1; break; end
    end
    r = dat_o;
    cyc = 0; stb = 0; we = 0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout actual=none required=ack addr=0x%08h", a);
    end
  endtask

  task automatic wbWrite(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] r;
    applyStimulus({27'd0, idx, 2'b00}, 1'b1, d, 4'hF, 1'b0, '0, r);
  endtask

  task automatic wbRead(input logic [2:0] idx, output logic [31:0] r);
    applyStimulus({27'd0, idx, 2'b00}, 1'b0, 32'd0, 4'hF, 1'b0, '0, r);
  endtask

  task automatic setCount(input logic [BITS-1:0] v);
    @(negedge clk);
    count = v;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r, tmp;
    logic [3:0]  pattern;
    cyc = 0; stb = 0; we = 0; sel = 0; dat_i = 0; adr = 0; count = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_dat", dat_o, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    rst_n = 1;

    // Held strobe: ack one cycle after valid, then every other cycle.
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'd0;
    pattern = '0;
    repeat (4) begin
      @(negedge clk);
      pattern = {pattern[2:0], ack};
      if (ack) checkOutput("ctrl_reset_read", dat_o, 32'd0);
    end
    cyc = 0; stb = 0;
    checkOutput("ack_pattern", 32'(pattern), 32'h0000_000A);

    // Single match with a stalled count.
    wbWrite(3'd1, 32'h10);
    wbWrite(3'd0, 32'h15);
    for (int v = 'h0E; v <= 'h12; v++) begin
      setCount(BITS'(v));
      if (v == 'h10) repeat (2) @(negedge clk);
    end
    wbRead(3'd3, r); checkOutput("single_status", r, 32'h1);
    wbRead(3'd5, r); checkOutput("single_level", r, 32'h1);
    checkOutput("single_irq", 32'(irq), 32'h1);
    wbRead(3'd4, r); checkOutput("single_fifo", r, 32'h4000_0010);
    wbWrite(3'd3, 32'h1);
    checkOutput("single_irq_clear", 32'(irq), 32'h0);

    // Dual simultaneous match.
    setCount('0);
    wbWrite(3'd1, 32'h20);
    wbWrite(3'd2, 32'h20);
    wbWrite(3'd0, 32'h07);
    setCount(BITS'(32'h20));
    repeat (2) @(negedge clk);
    wbRead(3'd5, r); checkOutput("dual_level", r, 32'h1);
    wbRead(3'd4, r); checkOutput("dual_fifo", r, 32'hC000_0020);
    wbRead(3'd3, r); checkOutput("dual_status", r, 32'h3);
    wbWrite(3'd3, 32'h7);

    // Overflow after five events with no reads.
    setCount('0);
    wbWrite(3'd0, 32'h45);
    for (int k = 0; k < 5; k++) begin
      wbWrite(3'd1, 32'h30 + k);
      setCount(BITS'(32'h30 + k));
      setCount('0);
    end
    wbRead(3'd5, r); checkOutput("ovf_level", r, 32'h4);
    wbRead(3'd3, r); checkOutput("ovf_status", r, 32'h5);
    checkOutput("ovf_irq", 32'(irq), 32'h4);
    checkOutput("model_depth", 32'(m_q.size()), 32'h4);
    for (int k = 0; k < 4; k++) begin
      wbRead(3'd4, r); checkOutput("ovf_fifo_order", r, 32'h4000_0030 + k);
    end
    wbRead(3'd4, r); checkOutput("empty_pop", r, 32'h0);
    wbRead(3'd5, r); checkOutput("empty_level", r, 32'h0);
    wbWrite(3'd3, 32'h7);

    // Full FIFO: pop and push in the same cycle.
    for (int k = 0; k < 4; k++) begin
      wbWrite(3'd1, 32'h40 + k);
      setCount(BITS'(32'h40 + k));
      setCount('0);
    end
    wbWrite(3'd1, 32'h44);
    applyStimulus(32'h10, 1'b0, 32'd0, 4'hF, 1'b1, BITS'(32'h44), r);
    checkOutput("full_pushpop_data", r, 32'h4000_0040);
    wbRead(3'd5, r); checkOutput("full_pushpop_level", r, 32'h4);
    wbRead(3'd3, r); checkOutput("full_pushpop_status", r, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      wbRead(3'd4, r); checkOutput("full_drain", r, 32'h4000_0040 + k);
    end

    // W1C racing a new event, then byte strobes on CMP1.
    setCount('0);
    wbWrite(3'd1, 32'h50);
    applyStimulus(32'hC, 1'b1, 32'h1, 4'hF, 1'b1, BITS'(32'h50), r);
    wbRead(3'd3, r); checkOutput("w1c_race", r, 32'h1);
    wbWrite(3'd2, 32'h0);
    applyStimulus(32'h8, 1'b1, 32'hFFFF_FFFF, 4'b0001, 1'b0, '0, r);
    wbRead(3'd2, r); checkOutput("sel_byte0", r, 32'h0000_00FF);
    applyStimulus(32'h8, 1'b1, 32'hA5A5_A5A5, 4'b1000, 1'b0, '0, r);
    wbRead(3'd2, r); checkOutput("sel_byte3", r, 32'h2500_00FF);

    // Counter wrap from max to zero matches a compare value of zero.
    setCount({BITS{1'b1}});
    wbWrite(3'd1, 32'h0);
    wbWrite(3'd3, 32'h7);
    setCount('0);
    @(negedge clk);
    wbRead(3'd3, r); checkOutput("wrap_status", r, 32'h1);

    // Reset in the middle of an access.
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h14;
    @(posedge clk);
    #1;
    checkOutput("midrst_ack_before", 32'(ack), 32'h1);
    rst_n = 0;
    #1;
    checkOutput("midrst_ack_after", 32'(ack), 32'h0);
    @(negedge clk);
    cyc = 0; stb = 0;
    @(negedge clk);
    rst_n = 1;
    wbRead(3'd5, r); checkOutput("midrst_level", r, 32'h0);
    wbRead(3'd0, r); checkOutput("midrst_ctrl", r, 32'h0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 700; i++) begin
      logic [2:0]  a;
      logic        w, sc;
      logic [31:0] d;
      logic [3:0]  s;
      a   = 3'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
      s   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      sc  = 1'($urandom_range(0, 1));
      tmp = $urandom;
      applyStimulus({tmp[31:5], a, tmp[1:0]}, w, d, s, sc, BITS'($urandom_range(0, 5)), r);
      if ($urandom_range(0, 2) == 0) setCount(BITS'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_cmp_capture.md
Name: count_cmp_capture

Overview:
- Downstream consumer of the user-area counter's `count` bus, sitting beside it inside the user project wrapper.
- Compares the live count against two Wishbone-programmable compare registers and flags each match.
- On a match it can timestamp the event into a 4-deep capture FIFO.
- Drives `user_irq[2:0]` and exposes all state over the Wishbone slave port.

Parameters:
- BITS, 30, width of the count bus and compare registers; legal range 1..30.
- FIFO_DEPTH, 4, capture FIFO entries; must be a power of 2, minimum 2.

Ports:
- wb_clk_i  input  1  single clock for all logic.
- wb_rst_i  input  1  reset, asynchronous assert, active-low (logic is held in reset while 0).
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  Wishbone write enable.
- wbs_sel_i  input  4  byte lane select; applies to writes only.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  byte address; only bits [4:2] are decoded.
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- count  input  BITS  live count from the counter stage.
- user_irq  output  3  level interrupts.

Behaviour:
- Reset values (while wb_rst_i=0): wbs_ack_o=0, wbs_dat_o=0, user_irq=0, all registers 0, FIFO empty, prev_match flags 0.
- Handshake:
  - valid = wbs_cyc_i & wbs_stb_i.
  - ack is registered: ack <= valid & ~ack. This gives one ack per access, 1-cycle latency, and never two consecutive acks.
  - Reads and writes take effect in the cycle ack is asserted. wbs_dat_o is registered alongside ack and is 0 when ack=0.
- Register map (wbs_adr_i[4:2]):
  - 0 CTRL (RW): [0] cmp0_en, [1] cmp1_en, [2] cap_en, [6:4] irq_en[2:0]; other bits read 0.
  - 1 CMP0 (RW, BITS wide).
  - 2 CMP1 (RW, BITS wide).
  - 3 STATUS (W1C): [0] m0, [1] m1, [2] ovf.
  - 4 FIFO_DATA (RO, pop on read): [31:30] tag {m1,m0}, [BITS-1:0] captured count.
  - 5 LEVEL (RO): [2:0] occupancy 0..FIFO_DEPTH.
  - Addresses 6–7 read 0; writes to them are ignored. Writes to RO registers are ignored.
- Byte strobes: CTRL, CMP0, CMP1 and STATUS honour wbs_sel_i per byte.
- Match detection:
  - hitN = cmpN_en & (count == CMPN).
  - A match event is the rising edge of hitN against a registered prev_hitN, so a stalled counter produces one event, not one per cycle.
  - A CMPN write that makes hitN true immediately also produces an edge event.
- Event effects (same cycle):
  - An event sets STATUS.mN.
  - If cap_en=1 and any event fires, exactly one FIFO push of {tag={ev1,ev0}, count}. Simultaneous CMP0 and CMP1 events give one entry with tag=2'b11.
- FIFO rules:
  - Push when full and no pop in the same cycle: data dropped, STATUS.ovf set.
  - Push and pop in the same cycle while full: both accepted, level unchanged, no ovf.
  - Pop when empty: returns 0, level stays 0, no state change.
- Sticky-bit priority: in the same cycle as a W1C, a hardware set wins, so the bit stays 1.
- Interrupts (combinational from flops only):
  - user_irq[0] = m0 & irq_en[0].
  - user_irq[1] = m1 & irq_en[1].
  - user_irq[2] = (fifo_nonempty | ovf) & irq_en[2].
- Count width: count and the CMPs are compared at BITS width with no sign extension. A counter wrap from max to 0 is a normal change; a compare value of 0 matches after the wrap.
- Reset mid-transaction: ack drops immediately; the master must retry the access.

Decomposition:
- Shared package `count_cmp_pkg`:
  - register word-index constants (ADDR_CTRL..ADDR_LEVEL);
  - CTRL and STATUS bit-position constants;
  - FIFO entry width expression BITS+2.
- One sub-module `capture_fifo`:
  - parameterised width/depth, synchronous push/pop, asynchronous active-low reset;
  - outputs full, empty, level, rdata (first-word fall-through).
- Wishbone decode, compare and IRQ logic stay in the top module.

Test Plan:
- Reset/ack: hold wb_rst_i=0 then release, read CTRL -> ack exactly 1 cycle after valid, data 0, user_irq=0; hold valid for 4 cycles -> ack pulses every other cycle.
- Single match: CMP0=0x10, CTRL=0x15 (cmp0_en, cap_en, irq_en0). Drive count 0x0E..0x12 and hold 0x10 for 3 cycles -> STATUS=1, LEVEL=1, FIFO_DATA=0x40000010, user_irq[0]=1. Write STATUS=1 -> irq clears.
- Dual simultaneous match: CMP0=CMP1=0x20, both enabled with capture, count=0x20 -> a single FIFO entry 0xC0000020 and STATUS=3.
- Overflow: cap_en=1, five distinct CMP0 events with no reads -> LEVEL=4, ovf=1, user_irq[2]=1 if irq_en2. The four entries read back in order; the fifth pop returns 0.
- Full push+pop: FIFO full, FIFO_DATA read in the same cycle as a match -> LEVEL stays 4, ovf stays 0.
- W1C race and byte strobes: STATUS W1C on m0 in the same cycle as a new m0 event -> m0 stays 1. Write CMP1 with sel=4'b0001 data 0xFFFFFFFF from 0 -> CMP1=0xFF.
